adc_spi_sampler: RTL and testbench

Upstream front-end for the proportional controller. Periodically runs a serial conversion on an external 12-bit SPI ADC (MCP3201-style: CS_n, SCLK, MISO, null/lead bits before MSB-first data). Publishes the latest complete 12-bit sample as `sensor_reading`, which drives the controller's `sensor_reading` input directly. Also produces a one-cycle `sample_valid` strobe per new sample.

---
 rtl/adc_pkg.sv | 22 ++
 rtl/adc_spi_sampler_if.sv | 21 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/adc_spi_sampler.sv | 145 ++++++++++++++
 tb/tb_adc_spi_sampler.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared types and derived constants for the SPI ADC sampler and its consumers.
package adc_pkg;

    localparam int ADC_DATA_BITS = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        CS_HOLD  = 2'd3
    } adc_state_t;

    function automatic int total_bits(input int lead_bits, input int data_bits);
        return lead_bits + data_bits;
    endfunction

    // clk cycles with chip select low: setup + all SCLK periods + hold
    function automatic int conv_cycles(input int clk_div, input int lead_bits, input int data_bits);
        return 2 * clk_div + 2 * clk_div * total_bits(lead_bits, data_bits);
    endfunction

endpackage

// File: rtl/adc_spi_sampler_if.sv
// SPI pins and sample outputs of the ADC sampler bundled as one port.
interface adc_spi_sampler_if import adc_pkg::*; #(
    parameter int DATA_BITS = ADC_DATA_BITS
) ();
    logic                 spi_cs_n;
    logic                 spi_sclk;
    logic                 spi_miso;
    logic [DATA_BITS-1:0] sensor_reading;
    logic                 sample_valid;
    logic                 busy;

    modport master (
        output spi_cs_n, spi_sclk, sensor_reading, sample_valid, busy,
        input  spi_miso
    );

    modport slave (
        input  spi_cs_n, spi_sclk, sensor_reading, sample_valid, busy,
        output spi_miso
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals arriving asynchronously to clk.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic MCP3201-style SPI conversion engine publishing the latest 12-bit sample.
//
// state    | meaning
// IDLE     | cs_n high, waiting for enable at period_cnt == 0
// CS_SETUP | cs_n low, sclk low for CLK_DIV cycles before the first bit
// SHIFT    | clocking lead + data bits, sampling at the end of each high phase
// CS_HOLD  | cs_n low for CLK_DIV cycles after the last bit, then release
module adc_spi_sampler import adc_pkg::*; #(
    parameter int CLK_DIV       = 4,
    parameter int DATA_BITS     = ADC_DATA_BITS,
    parameter int LEAD_BITS     = 3,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    adc_spi_sampler_if.master  spi
);
    localparam int TOTAL_BITS  = total_bits(LEAD_BITS, DATA_BITS);
    localparam int CONV_CYCLES = conv_cycles(CLK_DIV, LEAD_BITS, DATA_BITS);
    localparam int HW = $clog2(CLK_DIV);
    localparam int BW = $clog2(TOTAL_BITS);
    localparam int PW = $clog2(SAMPLE_PERIOD);

    localparam logic [HW-1:0] HALF_LAST   = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(TOTAL_BITS - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);

    if (CLK_DIV < 3) begin : g_bad_clk_div
        $error("adc_spi_sampler: CLK_DIV must be >= 3");
    end
    if (SAMPLE_PERIOD < CONV_CYCLES + 1) begin : g_bad_period
        $error("adc_spi_sampler: SAMPLE_PERIOD must be >= CONV_CYCLES+1");
    end
    if (DATA_BITS < 2) begin : g_bad_data_bits
        $error("adc_spi_sampler: DATA_BITS must be >= 2");
    end

    adc_state_t           state_q;
    logic [HW-1:0]        half_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [PW-1:0]        period_cnt_q;
    logic [PW-1:0]        period_cnt_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] reading_q;
    logic                 cs_n_q;
    logic                 sclk_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 miso_s;

    sync_2ff #(.WIDTH(1)) u_miso_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (spi.spi_miso),
        .q_o   (miso_s)
    );

    // Free-running conversion pacing, independent of enable and state
    always_comb begin
        period_cnt_d = period_cnt_q + 1'b1;
        if (period_cnt_q == PERIOD_LAST) begin
            period_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            reading_q  <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (enable && period_cnt_q == '0) begin
                        state_q    <= CS_SETUP;
                        cs_n_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        half_cnt_q <= HALF_LAST;
                    end
                end
                CS_SETUP: begin
                    if (half_cnt_q == '0) begin
                        state_q    <= SHIFT;
                        sclk_q     <= 1'b1;
                        half_cnt_q <= HALF_LAST;
                        bit_cnt_q  <= BIT_LAST;
                    end else begin
                        half_cnt_q <= half_cnt_q - 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_cnt_q != '0) begin
                        half_cnt_q <= half_cnt_q - 1'b1;
                    end else if (sclk_q) begin
                        // Lead bits simply fall off the top of the register
                        shift_q    <= {shift_q[DATA_BITS-2:0], miso_s};
                        sclk_q     <= 1'b0;
                        half_cnt_q <= HALF_LAST;
                    end else if (bit_cnt_q == '0) begin
                        reading_q  <= shift_q;
                        valid_q    <= 1'b1;
                        state_q    <= CS_HOLD;
                        half_cnt_q <= HALF_LAST;
                    end else begin
                        bit_cnt_q  <= bit_cnt_q - 1'b1;
                        sclk_q     <= 1'b1;
                        half_cnt_q <= HALF_LAST;
                    end
                end
                CS_HOLD: begin
                    if (half_cnt_q == '0) begin
                        state_q <= IDLE;
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        half_cnt_q <= half_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi.spi_cs_n       = cs_n_q;
    assign spi.spi_sclk       = sclk_q;
    assign spi.sensor_reading = reading_q;
    assign spi.sample_valid   = valid_q;
    assign spi.busy           = busy_q;
endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed scoreboard bench for adc_spi_sampler: default build plus a CLK_DIV=3 build with MISO glitches.
module tb_adc_spi_sampler;
    logic clk;
    logic reset;
    logic enable;
    logic reset_m;
    logic enable_m;

    adc_spi_sampler_if if_a ();
    adc_spi_sampler_if if_b ();

    adc_spi_sampler dut_a (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .spi    (if_a)
    );

    adc_spi_sampler #(.CLK_DIV(3), .SAMPLE_PERIOD(200)) dut_b (
        .clk    (clk),
        .reset  (reset_m),
        .enable (enable_m),
        .spi    (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [11:0] exp_a[$];
    logic [11:0] exp_b[$];
    logic [14:0] frame_a = '0;
    logic [14:0] frame_b = '0;

    // Observations recorded by the monitors, consumed by the main sequence
    int          cyc_a = 0;
    int          n_obs_a = 0;
    logic [11:0] obs_rd_a [32];
    int          obs_cyc_a [32];
    int          n_fall_a = 0;
    int          fall_cyc_a [32];
    int          n_conv_a = 0;
    int          conv_len_a [32];
    int          conv_rises_a [32];
    int          rises_a = 0;
    int          phase_bad_a = 0;
    int          dbl_a = 0;
    int          chg_a = 0;

    int          n_obs_b = 0;
    logic [11:0] obs_rd_b [32];

    // ADC model + monitor for the default build
    int          a_idx = -1;
    logic [14:0] a_cur = '0;
    logic        a_prev_cs = 1'b1;
    logic        a_prev_sclk = 1'b0;
    logic        a_prev_valid = 1'b0;
    logic [11:0] a_last_rd = '0;
    logic        a_skip = 1'b0;
    int          a_low = 0;
    int          a_hi = 0;
    int          a_lo = 0;

    always @(posedge clk) begin
        #1;
        cyc_a++;
        if (reset) a_skip = 1'b1;
        if (if_a.sample_valid && n_obs_a < 32) begin
            obs_rd_a[n_obs_a]  = if_a.sensor_reading;
            obs_cyc_a[n_obs_a] = cyc_a;
            n_obs_a++;
        end
        if (a_prev_valid && if_a.sample_valid) dbl_a++;
        if (if_a.sensor_reading !== a_last_rd && !if_a.sample_valid && !reset) chg_a++;
        a_last_rd    = if_a.sensor_reading;
        a_prev_valid = if_a.sample_valid;

        if (!if_a.spi_cs_n) begin
            if (a_prev_cs) begin
                a_low = 0; a_hi = 0; a_lo = 0; rises_a = 0; a_skip = 1'b0;
                if (n_fall_a < 32) fall_cyc_a[n_fall_a] = cyc_a;
                n_fall_a++;
            end
            a_low++;
            if (if_a.spi_sclk && !a_prev_sclk) begin
                rises_a++;
                if (!a_skip && a_lo != 4) phase_bad_a++;
                a_lo = 0;
            end
            if (!if_a.spi_sclk && a_prev_sclk) begin
                if (!a_skip && a_hi != 4) phase_bad_a++;
                a_hi = 0;
            end
            if (if_a.spi_sclk) a_hi++; else a_lo++;
        end else if (!a_prev_cs && n_conv_a < 32) begin
            conv_len_a[n_conv_a]   = a_skip ? -1 : a_low;
            conv_rises_a[n_conv_a] = a_skip ? -1 : rises_a;
            n_conv_a++;
        end

        if (a_prev_cs && !if_a.spi_cs_n) begin
            a_cur = frame_a;
            a_idx = 14;
        end else if (a_prev_sclk && !if_a.spi_sclk && !if_a.spi_cs_n) begin
            a_idx = a_idx - 1;
        end
        a_prev_cs   = if_a.spi_cs_n;
        a_prev_sclk = if_a.spi_sclk;
        if_a.spi_miso = (!if_a.spi_cs_n && a_idx >= 0) ? a_cur[a_idx] : 1'b0;
    end

    // ADC model for the CLK_DIV=3 build: MISO is inverted during the cycle before each sampling edge
    int          b_idx = -1;
    int          b_hcnt = 0;
    logic [14:0] b_cur = '0;
    logic        b_prev_cs = 1'b1;
    logic        b_prev_sclk = 1'b0;

    always @(posedge clk) begin
        #1;
        if (if_b.sample_valid && n_obs_b < 32) begin
            obs_rd_b[n_obs_b] = if_b.sensor_reading;
            n_obs_b++;
        end
        if (b_prev_cs && !if_b.spi_cs_n) begin
            b_cur = frame_b;
            b_idx = 14;
        end else if (b_prev_sclk && !if_b.spi_sclk && !if_b.spi_cs_n) begin
            b_idx = b_idx - 1;
        end
        b_hcnt = if_b.spi_sclk ? b_hcnt + 1 : 0;
        b_prev_cs   = if_b.spi_cs_n;
        b_prev_sclk = if_b.spi_sclk;
        if_b.spi_miso = (!if_b.spi_cs_n && b_idx >= 0) ? b_cur[b_idx] : 1'b0;
        if (b_hcnt == 3) if_b.spi_miso = ~if_b.spi_miso;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int rd_a = 0;
    int rd_b = 0;
    int cr_a = 0;

    task automatic consume_a(input string tag, input int budget, input logic spacing);
        int n = 0;
        logic [11:0] e;
        while (rd_a >= n_obs_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_arrived"}, 32'(rd_a < n_obs_a), 32'd1);
        if (rd_a < n_obs_a) begin
            e = (exp_a.size() > 0) ? exp_a.pop_front() : 12'hxxx;
            chk({tag, "_reading"}, 32'(obs_rd_a[rd_a]), 32'(e));
            if (spacing && rd_a > 0)
                chk({tag, "_spacing"}, obs_cyc_a[rd_a] - obs_cyc_a[rd_a-1], 32'd1000);
            rd_a++;
        end
    endtask

    task automatic conv_a(input string tag, input logic aborted);
        int n = 0;
        while (cr_a >= n_conv_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cs_rise"}, 32'(cr_a < n_conv_a), 32'd1);
        if (cr_a < n_conv_a) begin
            if (!aborted) begin
                chk({tag, "_cs_low_cycles"}, conv_len_a[cr_a], 32'd128);
                chk({tag, "_sclk_rises"}, conv_rises_a[cr_a], 32'd15);
            end
            cr_a++;
        end
    endtask

    task automatic wait_rises_a(input string tag, input int nf0, input int nr);
        int n = 0;
        while (!(n_fall_a > nf0 && rises_a >= nr) && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reached"}, 32'(n_fall_a > nf0 && rises_a >= nr), 32'd1);
    endtask

    task automatic consume_b(input string tag, input int budget);
        int n = 0;
        logic [11:0] e;
        while (rd_b >= n_obs_b && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_arrived"}, 32'(rd_b < n_obs_b), 32'd1);
        if (rd_b < n_obs_b) begin
            e = (exp_b.size() > 0) ? exp_b.pop_front() : 12'hxxx;
            chk({tag, "_no_x"}, 32'($isunknown(obs_rd_b[rd_b])), 32'd0);
            chk({tag, "_reading"}, 32'(obs_rd_b[rd_b]), 32'(e));
            rd_b++;
        end
    endtask

    int nf;

    initial begin
        reset = 1'b1; enable = 1'b1;
        reset_m = 1'b1; enable_m = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(if_a.spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(if_a.spi_sclk), 32'd0);
        chk("rst_reading", 32'(if_a.sensor_reading), 32'h000);
        chk("rst_valid", 32'(if_a.sample_valid), 32'd0);
        chk("rst_busy", 32'(if_a.busy), 32'd0);

        frame_a = {3'b000, 12'hA5C}; exp_a.push_back(12'hA5C);
        reset = 1'b0;
        @(negedge clk);
        chk("first_cs_fall", 32'(if_a.spi_cs_n), 32'd0);
        chk("busy_in_conv", 32'(if_a.busy), 32'd1);
        consume_a("a5c", 300, 1'b0);
        conv_a("a5c", 1'b0);

        frame_a = {3'b000, 12'hFFF}; exp_a.push_back(12'hFFF);
        consume_a("fff", 1200, 1'b1);
        conv_a("fff", 1'b0);
        frame_a = {3'b000, 12'h000}; exp_a.push_back(12'h000);
        consume_a("zero", 1200, 1'b1);
        conv_a("zero", 1'b0);

        frame_a = {3'b111, 12'h123}; exp_a.push_back(12'h123);
        consume_a("lead_ones", 1200, 1'b1);
        conv_a("lead_ones", 1'b0);

        frame_a = {3'b000, 12'h7FF}; exp_a.push_back(12'h7FF);
        wait_rises_a("en_drop_bit5", n_fall_a, 5);
        enable = 1'b0;
        consume_a("en_drop", 1200, 1'b0);
        conv_a("en_drop", 1'b0);
        @(negedge clk);
        chk("en_drop_busy_low", 32'(if_a.busy), 32'd0);
        chk("en_drop_cs_high", 32'(if_a.spi_cs_n), 32'd1);
        nf = n_fall_a;
        repeat (3000) @(negedge clk);
        chk("disabled_no_start", n_fall_a, nf);

        enable = 1'b1;
        frame_a = {3'b000, 12'h456}; exp_a.push_back(12'h456);
        consume_a("reenable", 1200, 1'b0);
        conv_a("reenable", 1'b0);
        chk("reenable_aligned", (fall_cyc_a[n_fall_a-1] - fall_cyc_a[0]) % 1000, 32'd0);

        frame_a = {3'b000, 12'h999};
        wait_rises_a("abort_bit7", n_fall_a, 7);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cs_n", 32'(if_a.spi_cs_n), 32'd1);
        chk("abort_sclk", 32'(if_a.spi_sclk), 32'd0);
        chk("abort_reading", 32'(if_a.sensor_reading), 32'h000);
        chk("abort_valid", 32'(if_a.sample_valid), 32'd0);
        chk("abort_busy", 32'(if_a.busy), 32'd0);
        frame_a = {3'b000, 12'h2B7}; exp_a.push_back(12'h2B7);
        reset = 1'b0;
        @(negedge clk);
        chk("restart_cs_fall", 32'(if_a.spi_cs_n), 32'd0);
        conv_a("aborted", 1'b1);
        consume_a("after_abort", 300, 1'b0);
        conv_a("after_abort", 1'b0);

        chk("a_extra_valids", n_obs_a, rd_a);
        chk("a_phase_len_errors", phase_bad_a, 32'd0);
        chk("a_multi_cycle_valid", dbl_a, 32'd0);
        chk("a_silent_reading_change", chg_a, 32'd0);

        frame_b = {3'b000, 12'h5A3}; exp_b.push_back(12'h5A3);
        enable_m = 1'b1;
        reset_m = 1'b0;
        consume_b("div3_5a3", 300);
        frame_b = {3'b111, 12'hC3F}; exp_b.push_back(12'hC3F);
        consume_b("div3_c3f", 400);
        frame_b = {3'b101, 12'h0F0}; exp_b.push_back(12'h0F0);
        consume_b("div3_0f0", 400);
        chk("b_extra_valids", n_obs_b, rd_b);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
